// File: rtl/stack_arbiter_pkg.sv
// Shared encodings and helpers for the stack arbiter and its round-robin picker.
package stack_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    localparam logic OP_POP  = 1'b0;
    localparam logic OP_PUSH = 1'b1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/stack_arbiter_rr.sv
// Combinational round-robin picker: the search starts one past last_id_i and wraps.
module rr_arbiter
    import stack_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    last_id_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    idx_o,
    output logic               vld_o
);

    logic [ID_W-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        cand  = '0;
        if (en_i) begin
            // Walk from farthest to nearest so the nearest hit is the one left standing.
            for (int k = NUM_REQ; k >= 1; k--) begin
                cand = ID_W'((int'(last_id_i) + k) % NUM_REQ);
                if (req_i[cand]) begin
                    gnt_o       = '0;
                    gnt_o[cand] = 1'b1;
                    idx_o       = cand;
                    vld_o       = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/stack_arbiter.sv
// Shares one stack between NUM_REQ requesters: one PUSH/POP strobe per grant, response one cycle later.
// Define STACK_ARB_ERR_EN to report rejected ops (full push / empty pop) through RSP_ERR.
module stack_arbiter
    import stack_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 2,
    parameter int ID_W       = (NUM_REQ > 1) ? clog2(NUM_REQ) : 1
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic [NUM_REQ-1:0]            REQ,
    input  logic [NUM_REQ-1:0]            REQ_OP,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
    output logic [NUM_REQ-1:0]            GNT,
    output logic                          RSP_VALID,
    output logic [ID_W-1:0]               RSP_ID,
    output logic [DATA_WIDTH-1:0]         RSP_DATA,
    output logic                          RSP_ERR,
    output logic                          BUSY,
    output logic                          STK_PUSH,
    output logic                          STK_POP,
    output logic [DATA_WIDTH-1:0]         STK_DATA_IN,
    input  logic [DATA_WIDTH-1:0]         STK_DATA_OUT,
    input  logic                          STK_FULL,
    input  logic                          STK_EMPTY
);

    state_e                state_q, state_d;
    logic [ID_W-1:0]       cur_id_q, cur_id_d;
    logic [ID_W-1:0]       last_id_q, last_id_d;
    logic [NUM_REQ-1:0]    gnt_q, gnt_d;
    logic                  op_q, op_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
`ifdef STACK_ARB_ERR_EN
    logic                  err_q, err_d;
`endif

    logic                  arb_en, arb_vld;
    logic [NUM_REQ-1:0]    arb_req, arb_gnt;
    logic [ID_W-1:0]       arb_idx;

    assign arb_en  = (state_q == IDLE) || (state_q == RESP);
    // The requester just served may still hold REQ during RESP; keep it out of this round.
    assign arb_req = (state_q == RESP) ? (REQ & ~gnt_q) : REQ;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .req_i     (arb_req),
        .last_id_i (last_id_q),
        .en_i      (arb_en),
        .gnt_o     (arb_gnt),
        .idx_o     (arb_idx),
        .vld_o     (arb_vld)
    );

    always_comb begin
        state_d   = state_q;
        cur_id_d  = cur_id_q;
        last_id_d = last_id_q;
        gnt_d     = gnt_q;
        op_d      = op_q;
        data_d    = data_q;
`ifdef STACK_ARB_ERR_EN
        err_d     = err_q;
`endif
        case (state_q)
            IDLE, RESP: begin
                state_d = IDLE;
                if (arb_vld) begin
                    state_d  = ISSUE;
                    cur_id_d = arb_idx;
                    gnt_d    = arb_gnt;
                    op_d     = REQ_OP[arb_idx];
                    data_d   = REQ_DATA[arb_idx*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            ISSUE: begin
                state_d   = RESP;
                last_id_d = cur_id_q;
`ifdef STACK_ARB_ERR_EN
                err_d     = (op_q == OP_PUSH) ? STK_FULL : STK_EMPTY;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            cur_id_q  <= '0;
            last_id_q <= ID_W'(NUM_REQ - 1);
            gnt_q     <= '0;
`ifdef STACK_ARB_ERR_EN
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cur_id_q  <= cur_id_d;
            last_id_q <= last_id_d;
            gnt_q     <= gnt_d;
`ifdef STACK_ARB_ERR_EN
            err_q     <= err_d;
`endif
        end
    end

    // Payload latches only matter once ISSUE is reached, so they carry no reset.
    always_ff @(posedge CLK) begin
        op_q   <= op_d;
        data_q <= data_d;
    end

    assign BUSY        = (state_q != IDLE);
    assign GNT         = (state_q == ISSUE) ? gnt_q : '0;
    assign STK_PUSH    = (state_q == ISSUE) && (op_q == OP_PUSH) && !STK_FULL;
    assign STK_POP     = (state_q == ISSUE) && (op_q == OP_POP) && !STK_EMPTY;
    assign STK_DATA_IN = STK_PUSH ? data_q : '0;
    assign RSP_VALID   = (state_q == RESP);
    assign RSP_ID      = RSP_VALID ? cur_id_q : '0;

`ifdef STACK_ARB_ERR_EN
    assign RSP_ERR  = RSP_VALID && err_q;
    assign RSP_DATA = (RSP_VALID && !err_q) ? STK_DATA_OUT : '0;
`else
    assign RSP_ERR  = 1'b0;
    assign RSP_DATA = RSP_VALID ? STK_DATA_OUT : '0;
`endif

endmodule

// File: tb/tb_stack_arbiter.sv
// Bench for stack_arbiter: behavioural 16-deep stack, reference stack queue and response scoreboard.
module tb_stack_arbiter;

    logic       CLK;
    logic       RST_N;
    logic [3:0] REQ;
    logic [3:0] REQ_OP;
    logic [7:0] REQ_DATA;
    logic [3:0] GNT;
    logic       RSP_VALID;
    logic [1:0] RSP_ID;
    logic [1:0] RSP_DATA;
    logic       RSP_ERR;
    logic       BUSY;
    logic       STK_PUSH;
    logic       STK_POP;
    logic [1:0] STK_DATA_IN;
    logic [1:0] STK_DATA_OUT;
    logic       STK_FULL;
    logic       STK_EMPTY;

`ifdef STACK_ARB_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    stack_arbiter #(.NUM_REQ(4), .DATA_WIDTH(2)) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .REQ          (REQ),
        .REQ_OP       (REQ_OP),
        .REQ_DATA     (REQ_DATA),
        .GNT          (GNT),
        .RSP_VALID    (RSP_VALID),
        .RSP_ID       (RSP_ID),
        .RSP_DATA     (RSP_DATA),
        .RSP_ERR      (RSP_ERR),
        .BUSY         (BUSY),
        .STK_PUSH     (STK_PUSH),
        .STK_POP      (STK_POP),
        .STK_DATA_IN  (STK_DATA_IN),
        .STK_DATA_OUT (STK_DATA_OUT),
        .STK_FULL     (STK_FULL),
        .STK_EMPTY    (STK_EMPTY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural stack: DATA_OUT shows the pushed word or the popped word after each op.
    logic [1:0] mem [16];
    logic [4:0] sp;
    logic [1:0] dout;
    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sp   <= '0;
            dout <= '0;
        end else if (STK_PUSH && sp != 5'd16) begin
            mem[sp[3:0]] <= STK_DATA_IN;
            sp           <= sp + 5'd1;
            dout         <= STK_DATA_IN;
        end else if (STK_POP && sp != 5'd0) begin
            sp   <= sp - 5'd1;
            dout <= mem[sp[3:0] - 4'd1];
        end
    end
    assign STK_DATA_OUT = dout;
    assign STK_FULL     = (sp == 5'd16);
    assign STK_EMPTY    = (sp == 5'd0);

    typedef struct packed {
        logic [1:0] id;
        logic [1:0] data;
        logic       err;
    } exp_t;

    exp_t       sb[$];
    logic [1:0] ref_stk[$];
    logic [1:0] ref_dout;
    int         passed;
    int         total;

    // Reference model: decides whether the op is legal and queues the expected response.
    task automatic predict(input logic [1:0] id, input logic op, input logic [1:0] d,
                           output logic e_push, output logic e_pop);
        exp_t e;
        logic bad;
        e.id   = id;
        e.data = '0;
        e.err  = 1'b0;
        e_push = 1'b0;
        e_pop  = 1'b0;
        bad    = 1'b0;
        if (op) begin
            if (ref_stk.size() < 16) begin
                ref_stk.push_back(d);
                ref_dout = d;
                e_push   = 1'b1;
                e.data   = d;
            end else bad = 1'b1;
        end else begin
            if (ref_stk.size() > 0) begin
                ref_dout = ref_stk.pop_back();
                e_pop    = 1'b1;
                e.data   = ref_dout;
            end else bad = 1'b1;
        end
        if (bad) begin
`ifdef STACK_ARB_ERR_EN
            e.err  = 1'b1;
            e.data = '0;
`else
            e.data = ref_dout;
`endif
        end
        sb.push_back(e);
    endtask

    task automatic do_reset();
        RST_N    = 1'b0;
        REQ      = '0;
        REQ_OP   = '0;
        REQ_DATA = '0;
        repeat (2) @(negedge CLK);
        ref_stk.delete();
        sb.delete();
        ref_dout = '0;
        RST_N    = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({GNT, RSP_VALID, RSP_ID, RSP_DATA, RSP_ERR, BUSY} !== 10'b0) begin
            $display("FAIL reset_rsp: gnt=%b vld=%b id=%0d data=%b err=%b busy=%b, want all 0",
                     GNT, RSP_VALID, RSP_ID, RSP_DATA, RSP_ERR, BUSY);
        end else passed++;
        total++;
        if ({STK_PUSH, STK_POP, STK_DATA_IN} !== 4'b0) begin
            $display("FAIL reset_stk: push=%b pop=%b din=%b, want 0 0 00", STK_PUSH, STK_POP, STK_DATA_IN);
        end else passed++;
    endtask

    task automatic test_single_push();
        do_reset();
        REQ_OP   = 4'b0001;
        REQ_DATA = 8'b0000_0010;
        REQ      = 4'b0001;
        @(negedge CLK);
        total++;
        if ({GNT, STK_PUSH, STK_POP, STK_DATA_IN, BUSY} !== {4'b0001, 1'b1, 1'b0, 2'b10, 1'b1}) begin
            $display("FAIL single_issue: gnt=%b push=%b pop=%b din=%b busy=%b, want 0001 1 0 10 1",
                     GNT, STK_PUSH, STK_POP, STK_DATA_IN, BUSY);
        end else passed++;
        REQ = '0;
        @(negedge CLK);
        total++;
        if ({RSP_VALID, RSP_ID, RSP_DATA, RSP_ERR, GNT, STK_PUSH} !== {1'b1, 2'd0, 2'b10, 1'b0, 4'b0, 1'b0}) begin
            $display("FAIL single_rsp: vld=%b id=%0d data=%b err=%b gnt=%b push=%b, want 1 0 10 0 0000 0",
                     RSP_VALID, RSP_ID, RSP_DATA, RSP_ERR, GNT, STK_PUSH);
        end else passed++;
        @(negedge CLK);
        total++;
        if ({RSP_VALID, BUSY} !== 2'b00) begin
            $display("FAIL single_idle: vld=%b busy=%b, want 0 0", RSP_VALID, BUSY);
        end else passed++;
    endtask

    task automatic test_pop_empty();
        do_reset();
        REQ_OP = 4'b0000;
        REQ    = 4'b0100;
        @(negedge CLK);
        total++;
        if ({GNT, STK_POP, STK_PUSH} !== {4'b0100, 1'b0, 1'b0}) begin
            $display("FAIL popempty_issue: gnt=%b pop=%b push=%b, want 0100 0 0", GNT, STK_POP, STK_PUSH);
        end else passed++;
        REQ = '0;
        @(negedge CLK);
        total++;
        if ({RSP_VALID, RSP_ID, RSP_DATA, RSP_ERR} !== {1'b1, 2'd2, 2'b00, ERR_EN}) begin
            $display("FAIL popempty_rsp: vld=%b id=%0d data=%b err=%b, want 1 2 00 %b",
                     RSP_VALID, RSP_ID, RSP_DATA, RSP_ERR, ERR_EN);
        end else passed++;
    endtask

    task automatic test_fairness();
        int g, cyc, last_cyc, exp_id;
        logic ep, epo;
        exp_t e;
        do_reset();
        REQ_OP   = 4'b1111;
        REQ_DATA = 8'b11_10_01_00;
        REQ      = 4'b1111;
        g = 0; cyc = 0; last_cyc = 0;
        while ((g < 5 || sb.size() > 0) && cyc < 40) begin
            @(negedge CLK);
            cyc++;
            total++;
            if ((STK_PUSH & STK_POP) !== 1'b0) begin
                $display("FAIL fair_overlap: push=%b pop=%b, want not both", STK_PUSH, STK_POP);
            end else passed++;
            if (RSP_VALID === 1'b1) begin
                total++;
                if (sb.size() == 0) begin
                    $display("FAIL fair_rsp_unexpected: id=%0d data=%b, want no response", RSP_ID, RSP_DATA);
                end else begin
                    e = sb.pop_front();
                    if ({RSP_ID, RSP_DATA, RSP_ERR} !== {e.id, e.data, e.err}) begin
                        $display("FAIL fair_rsp: id=%0d data=%b err=%b, want %0d %b %b",
                                 RSP_ID, RSP_DATA, RSP_ERR, e.id, e.data, e.err);
                    end else passed++;
                end
            end
            if (GNT !== 4'b0) begin
                exp_id = g % 4;
                predict(2'(exp_id), 1'b1, 2'(exp_id), ep, epo);
                total++;
                if (GNT !== 4'(1 << exp_id) || STK_PUSH !== ep || (g > 0 && cyc - last_cyc != 2)) begin
                    $display("FAIL fair_gnt%0d: gnt=%b push=%b spacing=%0d, want %b %b 2",
                             g, GNT, STK_PUSH, cyc - last_cyc, 4'(1 << exp_id), ep);
                end else passed++;
                last_cyc = cyc;
                g++;
                if (g == 5) REQ = '0;
            end
        end
        total++;
        if (g < 5 || sb.size() > 0) begin
            $display("FAIL fair_timeout: grants=%0d pending=%0d, want 5 0", g, sb.size());
        end else passed++;
    endtask

    task automatic test_back_to_back();
        int g, cyc, exp_id;
        logic ep, epo;
        exp_t e;
        do_reset();
        // Requesters 0,1 push 1 and 2; requesters 2,3 pop them back in LIFO order.
        REQ_OP   = 4'b0011;
        REQ_DATA = 8'b00_00_10_01;
        REQ      = 4'b1111;
        g = 0; cyc = 0;
        while ((g < 4 || sb.size() > 0) && cyc < 30) begin
            @(negedge CLK);
            cyc++;
            if (RSP_VALID === 1'b1) begin
                total++;
                if (sb.size() == 0) begin
                    $display("FAIL b2b_rsp_unexpected: id=%0d, want no response", RSP_ID);
                end else begin
                    e = sb.pop_front();
                    if ({RSP_ID, RSP_DATA, RSP_ERR} !== {e.id, e.data, e.err}) begin
                        $display("FAIL b2b_rsp: id=%0d data=%b err=%b, want %0d %b %b",
                                 RSP_ID, RSP_DATA, RSP_ERR, e.id, e.data, e.err);
                    end else passed++;
                end
            end
            if (GNT !== 4'b0) begin
                exp_id = g;
                predict(2'(exp_id), REQ_OP[exp_id], REQ_DATA[exp_id*2 +: 2], ep, epo);
                total++;
                if ({GNT, STK_PUSH, STK_POP} !== {4'(1 << exp_id), ep, epo}) begin
                    $display("FAIL b2b_gnt%0d: gnt=%b push=%b pop=%b, want %b %b %b",
                             g, GNT, STK_PUSH, STK_POP, 4'(1 << exp_id), ep, epo);
                end else passed++;
                REQ[exp_id] = 1'b0;
                g++;
            end
        end
        total++;
        if (g != 4 || sb.size() > 0) begin
            $display("FAIL b2b_timeout: grants=%0d pending=%0d, want 4 0", g, sb.size());
        end else passed++;
    endtask

    task automatic test_full_stack();
        int cyc;
        logic op, ep, epo;
        logic [1:0] d;
        exp_t e;
        do_reset();
        for (int i = 0; i < 18; i++) begin
            op          = (i < 17);
            d           = 2'(i);
            REQ_OP[1]   = op;
            REQ_DATA[3:2] = d;
            REQ[1]      = 1'b1;
            @(negedge CLK);
            cyc = 0;
            while (GNT === 4'b0 && cyc < 8) begin
                @(negedge CLK);
                cyc++;
            end
            total++;
            if (GNT === 4'b0) begin
                $display("FAIL full_timeout%0d: gnt=%b, want 0010 within 8 cycles", i, GNT);
                REQ = '0;
            end else begin
                predict(2'd1, op, d, ep, epo);
                if ({GNT, STK_PUSH, STK_POP, STK_DATA_IN} !== {4'b0010, ep, epo, (ep ? d : 2'b00)}) begin
                    $display("FAIL full_issue%0d: gnt=%b push=%b pop=%b din=%b, want 0010 %b %b %b",
                             i, GNT, STK_PUSH, STK_POP, STK_DATA_IN, ep, epo, (ep ? d : 2'b00));
                end else passed++;
                REQ[1] = 1'b0;
                @(negedge CLK);
                e = sb.pop_front();
                total++;
                if ({RSP_VALID, RSP_ID, RSP_DATA, RSP_ERR} !== {1'b1, e.id, e.data, e.err}) begin
                    $display("FAIL full_rsp%0d: vld=%b id=%0d data=%b err=%b, want 1 %0d %b %b",
                             i, RSP_VALID, RSP_ID, RSP_DATA, RSP_ERR, e.id, e.data, e.err);
                end else passed++;
            end
        end
    endtask

    task automatic test_withdraw();
        logic ep, epo, saw2;
        exp_t e;
        do_reset();
        REQ_OP   = 4'b1111;
        REQ_DATA = 8'b11_10_01_00;
        REQ      = 4'b0110;
        @(negedge CLK);
        predict(2'd1, 1'b1, 2'b01, ep, epo);
        total++;
        if ({GNT, STK_PUSH} !== {4'b0010, ep}) begin
            $display("FAIL wd_gnt1: gnt=%b push=%b, want 0010 %b", GNT, STK_PUSH, ep);
        end else passed++;
        // Requester 2 withdraws while requester 3 arrives.
        REQ = 4'b1000;
        @(negedge CLK);
        e = sb.pop_front();
        total++;
        if ({RSP_VALID, RSP_ID, RSP_DATA, RSP_ERR} !== {1'b1, e.id, e.data, e.err}) begin
            $display("FAIL wd_rsp1: vld=%b id=%0d data=%b err=%b, want 1 %0d %b %b",
                     RSP_VALID, RSP_ID, RSP_DATA, RSP_ERR, e.id, e.data, e.err);
        end else passed++;
        @(negedge CLK);
        predict(2'd3, 1'b1, 2'b11, ep, epo);
        total++;
        if ({GNT, STK_PUSH} !== {4'b1000, ep}) begin
            $display("FAIL wd_gnt3: gnt=%b push=%b, want 1000 %b", GNT, STK_PUSH, ep);
        end else passed++;
        REQ = '0;
        @(negedge CLK);
        e = sb.pop_front();
        total++;
        if ({RSP_VALID, RSP_ID, RSP_DATA, RSP_ERR} !== {1'b1, e.id, e.data, e.err}) begin
            $display("FAIL wd_rsp3: vld=%b id=%0d data=%b err=%b, want 1 %0d %b %b",
                     RSP_VALID, RSP_ID, RSP_DATA, RSP_ERR, e.id, e.data, e.err);
        end else passed++;
        saw2 = 1'b0;
        repeat (4) begin
            @(negedge CLK);
            saw2 = saw2 | (GNT[2] === 1'b1);
        end
        total++;
        if (saw2 !== 1'b0) begin
            $display("FAIL wd_req2_granted: saw2=%b, want 0", saw2);
        end else passed++;
    endtask

    task automatic test_reset_in_issue();
        logic seen_rsp, seen_gnt;
        do_reset();
        REQ_OP   = 4'b0001;
        REQ_DATA = 8'b0000_0001;
        REQ      = 4'b0001;
        @(negedge CLK);
        total++;
        if ({GNT, STK_PUSH} !== {4'b0001, 1'b1}) begin
            $display("FAIL rstiss_gnt: gnt=%b push=%b, want 0001 1", GNT, STK_PUSH);
        end else passed++;
        RST_N = 1'b0;
        #1;
        total++;
        if ({GNT, RSP_VALID, RSP_ID, RSP_DATA, RSP_ERR, BUSY, STK_PUSH, STK_POP, STK_DATA_IN} !== 14'b0) begin
            $display("FAIL rstiss_outputs: gnt=%b vld=%b id=%0d data=%b err=%b busy=%b push=%b pop=%b din=%b, want all 0",
                     GNT, RSP_VALID, RSP_ID, RSP_DATA, RSP_ERR, BUSY, STK_PUSH, STK_POP, STK_DATA_IN);
        end else passed++;
        REQ = '0;
        ref_stk.delete();
        sb.delete();
        ref_dout = '0;
        @(negedge CLK);
        RST_N    = 1'b1;
        seen_rsp = 1'b0;
        seen_gnt = 1'b0;
        repeat (4) begin
            @(negedge CLK);
            seen_rsp = seen_rsp | (RSP_VALID !== 1'b0);
            seen_gnt = seen_gnt | (GNT !== 4'b0);
        end
        total++;
        if ({seen_rsp, seen_gnt, BUSY} !== 3'b000) begin
            $display("FAIL rstiss_after: rsp_seen=%b gnt_seen=%b busy=%b, want 0 0 0", seen_rsp, seen_gnt, BUSY);
        end else passed++;
    endtask

    initial begin
        passed   = 0;
        total    = 0;
        RST_N    = 1'b0;
        REQ      = '0;
        REQ_OP   = '0;
        REQ_DATA = '0;
        ref_dout = '0;
        test_reset();
        test_single_push();
        test_pop_empty();
        test_fairness();
        test_back_to_back();
        test_full_stack();
        test_withdraw();
        test_reset_in_issue();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", passed, total);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/stack_arbiter.md
# stack_arbiter

Round-robin arbiter and sequencer that shares one `stack` instance between `NUM_REQ` requesters (player input, replay engine, scorer). It accepts push/pop requests, issues exactly one single-cycle `PUSH` or `POP` strobe per granted request, and returns the popped or pushed data with a per-op error flag. It sits directly in front of the stack; requesters never touch stack ports.

## Interface
- `NUM_REQ`, 4: number of requesters, 1..8
- `DATA_WIDTH`, 2: stack word width; must match the stack
- `ID_W`, `clog2(NUM_REQ)`, minimum 1: requester index width

- Reset `RST_N`, asynchronous, active-low; clock `CLK`.
- `CLK`  in  1  clock
- `RST_N`  in  1  async active-low reset
- `REQ`  in  NUM_REQ  per-requester request, held until GNT
- `REQ_OP`  in  NUM_REQ  per-requester op: 1 = push, 0 = pop
- `REQ_DATA`  in  NUM_REQ*DATA_WIDTH  push data; requester i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- `GNT`  out  NUM_REQ  one-hot grant, single-cycle pulse
- `RSP_VALID`  out  1  response strobe, single cycle
- `RSP_ID`  out  ID_W  index of requester being answered
- `RSP_DATA`  out  DATA_WIDTH  stack `DATA_OUT` sampled for this op
- `RSP_ERR`  out  1  op rejected (see Configuration)
- `BUSY`  out  1  high in every state other than IDLE
- `STK_PUSH`, `STK_POP`  out  1  strobes to the stack
- `STK_DATA_IN`  out  DATA_WIDTH  data to the stack
- `STK_DATA_OUT`  in  DATA_WIDTH  stack `DATA_OUT`
- `STK_FULL`, `STK_EMPTY`  in  1  stack flags

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE: if any `REQ` bit is high, latch the round-robin winner into `cur_id`, latch `REQ_OP`/`REQ_DATA` of that requester, go to ISSUE. Otherwise stay.
- ISSUE: assert `GNT[cur_id]`. A push is legal if `!STK_FULL`; a pop is legal if `!STK_EMPTY`. A legal op asserts `STK_PUSH` or `STK_POP` for this cycle only, with `STK_DATA_IN` = latched data. An illegal op drives no strobe and sets the `err` register. Go to RESP.
- RESP: assert `RSP_VALID`, drive `RSP_ID` = `cur_id`, `RSP_DATA` = `STK_DATA_OUT`, `RSP_ERR` = `err`. If any `REQ` is high, arbitrate as in IDLE and go directly to ISSUE. Otherwise go to IDLE.
- Round-robin: search starts at `last_id+1` mod NUM_REQ. `last_id` updates on every grant, including rejected ops. Reset `last_id` = NUM_REQ-1, so requester 0 wins first.
- The winner's `REQ` bit is ignored in RESP. The requester drops it after seeing `GNT`.
- A requester that deasserts `REQ` before its grant is simply skipped.
- `STK_PUSH` and `STK_POP` are never high together and never high outside ISSUE.
- `STK_DATA_IN` is 0 whenever `STK_PUSH` is low.
- `NUM_REQ` = 1 degenerates to a fixed grant with the same timing.

## Timing
- All outputs are registered or decoded from the state register only. There is no combinational path from `REQ` to any output.
- Reset values: state IDLE, `GNT` 0, `RSP_VALID` 0, `RSP_ID` 0, `RSP_DATA` 0, `RSP_ERR` 0, `BUSY` 0, `STK_PUSH` 0, `STK_POP` 0, `STK_DATA_IN` 0, `err` 0.
- Latency: `REQ` high at edge N (state IDLE) gives `GNT` and the strobe in cycle N+1, and `RSP_VALID` in cycle N+2.
- Back-to-back throughput: one op per 2 cycles (RESP→ISSUE).
- The stack updates `DATA_OUT` and its flags on the edge that ends ISSUE. RESP therefore samples post-op values, and the next ISSUE checks updated flags.
- Reset mid-operation: asynchronous return to IDLE. Any in-flight response is dropped with no `RSP_VALID`. The stack shares `RST_N` and empties at the same time.

## Configuration
- `STACK_ARB_ERR_EN` defined: rejected ops report `RSP_ERR` = 1 in RESP, and `RSP_DATA` = 0 for them.
- `STACK_ARB_ERR_EN` undefined: the `err` register is removed and `RSP_ERR` is tied 0. A rejected op still issues no strobe and still returns `RSP_VALID` with `RSP_DATA` = `STK_DATA_OUT`.

## Structure
- Shared header/package holds:
  - state encodings: IDLE=2'd0, ISSUE=2'd1, RESP=2'd2
  - op encodings: OP_POP=1'b0, OP_PUSH=1'b1
  - the existing `clog2` function include
- Sub-module `rr_arbiter`: parameterised by NUM_REQ. Inputs: request vector, `last_id`, enable. Outputs: combinational one-hot winner and index.
- The FSM, data latches and stack interface stay in `stack_arbiter`.

## Test plan
- Single push: `REQ`=4'b0001, `REQ_OP[0]`=1, data 2'b10 on an empty stack → `GNT`=0001 and `STK_PUSH` in cycle 1; `RSP_VALID`, `RSP_ID`=0, `RSP_DATA`=2'b10, `RSP_ERR`=0 in cycle 2.
- Fairness: all four `REQ` held high with pushes → grants in order 0,1,2,3,0 at 2-cycle spacing; no `STK_PUSH`/`STK_POP` overlap.
- Pop from empty (ERR_EN defined): `REQ[2]` pop after reset → no `STK_POP`; `RSP_ERR`=1, `RSP_ID`=2, `RSP_DATA`=0.
- Full stack: 16 pushes then a 17th push → 17th has no `STK_PUSH` and `RSP_ERR`=1; a following pop is issued and `RSP_ERR`=0.
- Early withdrawal: `REQ`=0110, and `REQ[2]` drops while requester 1 is served → next grant goes to nobody or to requester 3 only; requester 2 is never granted.
- Reset in ISSUE: assert `RST_N`=0 during the cycle `GNT` is high → all outputs 0 immediately; no `RSP_VALID` after release.
